// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared types and constants for the memory responder.
//   ch_state_e - per-channel request state
//   LAT_CNT_W  - width of the per-channel latency counter (LATENCY up to 15)
//   STAT_W     - width of the optional access statistics counters
package mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESPOND = 2'd2,
    ST_RELEASE = 2'd3
  } ch_state_e;

  localparam int unsigned LAT_CNT_W = 4;
  localparam int unsigned STAT_W    = 16;

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: multi-channel memory request bus plus backdoor load port.
//   master - request side (core memory controllers / testbench)
//   slave  - responder side (mem_responder)
// Signals per channel are packed: channel c occupies slice [c*W +: W].
// When MEM_RESPONDER_STATS_EN is defined the bus also carries stat_reads and
// stat_writes (driven by the responder).
interface mem_responder_if #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned CHANNELS  = 4
);
  import mem_responder_pkg::*;

  logic [CHANNELS-1:0]           read_valid;
  logic [CHANNELS*ADDR_BITS-1:0] read_address;
  logic [CHANNELS-1:0]           read_ready;
  logic [CHANNELS*DATA_BITS-1:0] read_data;
  logic [CHANNELS-1:0]           write_valid;
  logic [CHANNELS*ADDR_BITS-1:0] write_address;
  logic [CHANNELS*DATA_BITS-1:0] write_data;
  logic [CHANNELS-1:0]           write_ready;
  logic                          load_en;
  logic [ADDR_BITS-1:0]          load_addr;
  logic [DATA_BITS-1:0]          load_data;
  logic                          busy;

`ifdef MEM_RESPONDER_STATS_EN
  logic [STAT_W-1:0] stat_reads;
  logic [STAT_W-1:0] stat_writes;

  modport master (
    output read_valid, read_address, write_valid, write_address, write_data,
           load_en, load_addr, load_data,
    input  read_ready, read_data, write_ready, busy, stat_reads, stat_writes
  );
  modport slave (
    input  read_valid, read_address, write_valid, write_address, write_data,
           load_en, load_addr, load_data,
    output read_ready, read_data, write_ready, busy, stat_reads, stat_writes
  );
`else
  modport master (
    output read_valid, read_address, write_valid, write_address, write_data,
           load_en, load_addr, load_data,
    input  read_ready, read_data, write_ready, busy
  );
  modport slave (
    input  read_valid, read_address, write_valid, write_address, write_data,
           load_en, load_addr, load_data,
    output read_ready, read_data, write_ready, busy
  );
`endif

endinterface

// File: rtl/mem_responder_rr_arbiter.sv
// rr_arbiter: round-robin arbiter over CHANNELS requesters.
//   clk, reset_n - clock, asynchronous active-low reset (pointer -> 0)
//   req          - request vector
//   en           - when low no grant is issued and the pointer holds
//   grant        - one-hot grant (combinational on req and the pointer)
//   ptr          - registered search-start pointer
module rr_arbiter #(
  parameter  int unsigned CHANNELS = 4,
  localparam int unsigned PTR_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] req,
  input  logic                en,
  output logic [CHANNELS-1:0] grant,
  output logic [PTR_W-1:0]    ptr
);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] idx;
  logic             found;

  // First requester at or after the pointer wins; pointer moves past it.
  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    if (en) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        idx = PTR_W'((32'(ptr_q) + i) % CHANNELS);
        if (!found && req[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          ptr_d      = PTR_W'((32'(idx) + 1) % CHANNELS);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/mem_responder.sv
// mem_responder: device-side responder for the multi-channel memory request bus.
//   clk     - clock
//   reset_n - asynchronous active-low reset (array contents are kept)
//   bus     - mem_responder_if.slave: per-channel read/write requests held until
//             a one-cycle ready pulse, backdoor load port, busy flag.
// Channels are arbitrated round-robin onto one single-port array, one access per
// cycle; ready pulses LATENCY cycles after the grant. A load_en cycle writes the
// backdoor word and blocks all grants.
// Optional: `define MEM_RESPONDER_STATS_EN adds saturating stat_reads/stat_writes.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned LATENCY   = 2
) (
  input logic            clk,
  input logic            reset_n,
  mem_responder_if.slave bus
);

  localparam int unsigned PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("mem_responder: LATENCY must be within 1..15");
  end

  ch_state_e            state_q [CHANNELS];
  ch_state_e            state_d [CHANNELS];
  logic [LAT_CNT_W-1:0] cnt_q   [CHANNELS];
  logic [LAT_CNT_W-1:0] cnt_d   [CHANNELS];
  logic [DATA_BITS-1:0] rdata_q [CHANNELS];
  logic [DATA_BITS-1:0] rdata_d [CHANNELS];
  logic [CHANNELS-1:0]  is_wr_q, is_wr_d;

  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  logic [CHANNELS-1:0]  req, grant;
  logic [PTR_W-1:0]     arb_ptr;
  logic                 arb_en;

  logic                 acc_we;
  logic [ADDR_BITS-1:0] acc_waddr, acc_raddr;
  logic [DATA_BITS-1:0] acc_wdata, rd_word;

  // Only channels sitting in IDLE may compete; RELEASE blocks re-triggering.
  always_comb begin
    req = '0;
    for (int unsigned c = 0; c < CHANNELS; c++)
      req[c] = (state_q[c] == ST_IDLE) && (bus.read_valid[c] || bus.write_valid[c]);
  end

  // Grants are held off during reset so a held request cannot touch the array.
  assign arb_en = !bus.load_en && reset_n;

  rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .en      (arb_en),
    .grant   (grant),
    .ptr     (arb_ptr)
  );

  // Single array port: the backdoor load or the granted channel's access.
  always_comb begin
    acc_we    = bus.load_en;
    acc_waddr = bus.load_addr;
    acc_wdata = bus.load_data;
    acc_raddr = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (grant[c]) begin
        acc_raddr = bus.read_address[c*ADDR_BITS +: ADDR_BITS];
        if (bus.write_valid[c]) begin
          acc_we    = 1'b1;
          acc_waddr = bus.write_address[c*ADDR_BITS +: ADDR_BITS];
          acc_wdata = bus.write_data[c*DATA_BITS +: DATA_BITS];
        end
      end
    end
  end

  assign rd_word = mem[acc_raddr];

  always_ff @(posedge clk) begin
    if (acc_we) mem[acc_waddr] <= acc_wdata;
  end

  // Per-channel FSM; a write wins over a same-cycle read on one channel.
  always_comb begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      rdata_d[c] = rdata_q[c];
      is_wr_d[c] = is_wr_q[c];
      unique case (state_q[c])
        ST_IDLE: begin
          if (grant[c]) begin
            is_wr_d[c] = bus.write_valid[c];
            if (!bus.write_valid[c]) rdata_d[c] = rd_word;
            if (LATENCY == 1) begin
              state_d[c] = ST_RESPOND;
            end else begin
              state_d[c] = ST_WAIT;
              cnt_d[c]   = LAT_CNT_W'(LATENCY - 1);
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q[c] == LAT_CNT_W'(1)) state_d[c] = ST_RESPOND;
          cnt_d[c] = cnt_q[c] - LAT_CNT_W'(1);
        end
        ST_RESPOND: state_d[c] = ST_RELEASE;
        ST_RELEASE: begin
          if (!bus.read_valid[c] && !bus.write_valid[c]) state_d[c] = ST_IDLE;
        end
        default: state_d[c] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        state_q[c] <= ST_IDLE;
        cnt_q[c]   <= '0;
        rdata_q[c] <= '0;
      end
      is_wr_q <= '0;
    end else begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
        rdata_q[c] <= rdata_d[c];
      end
      is_wr_q <= is_wr_d;
    end
  end

  always_comb begin
    bus.read_ready  = '0;
    bus.write_ready = '0;
    bus.read_data   = '0;
    bus.busy        = 1'b0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      bus.read_ready[c]                      = (state_q[c] == ST_RESPOND) && !is_wr_q[c];
      bus.write_ready[c]                     = (state_q[c] == ST_RESPOND) &&  is_wr_q[c];
      bus.read_data[c*DATA_BITS +: DATA_BITS] = rdata_q[c];
      if (state_q[c] != ST_IDLE) bus.busy = 1'b1;
    end
  end

`ifdef MEM_RESPONDER_STATS_EN
  logic [STAT_W-1:0] stat_reads_q, stat_reads_d;
  logic [STAT_W-1:0] stat_writes_q, stat_writes_d;

  always_comb begin
    stat_reads_d  = stat_reads_q;
    stat_writes_d = stat_writes_q;
    if (|(grant & ~bus.write_valid) && (stat_reads_q != '1))
      stat_reads_d = stat_reads_q + STAT_W'(1);
    if (|(grant & bus.write_valid) && (stat_writes_q != '1))
      stat_writes_d = stat_writes_q + STAT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_reads_q  <= '0;
      stat_writes_q <= '0;
    end else begin
      stat_reads_q  <= stat_reads_d;
      stat_writes_q <= stat_writes_d;
    end
  end

  assign bus.stat_reads  = stat_reads_q;
  assign bus.stat_writes = stat_writes_q;
`endif

  ptr_in_range_a: assert property (@(posedge clk) disable iff (!reset_n)
    32'(arb_ptr) < CHANNELS);
  grant_onehot_a: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(grant));

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
  localparam int AB  = 8;
  localparam int DB  = 8;
  localparam int CH  = 4;
  localparam int LAT = 2;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   errors  = 0;
  int   checks  = 0;

  mem_responder_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .CHANNELS(CH)) bus ();

  mem_responder #(.ADDR_BITS(AB), .DATA_BITS(DB), .CHANNELS(CH), .LATENCY(LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model: per channel a request is either in flight (with the cycle
  // its ready is due), waiting for valids to drop, or free.
  logic [DB-1:0] m_mem [256];
  bit            m_infl [CH];
  bit            m_rel  [CH];
  bit            m_wr   [CH];
  int            m_done [CH];
  logic [DB-1:0] m_rdata[CH];
  int            m_ptr, m_sr, m_sw;
  int            cyc = 0;

  logic [CH-1:0]    exp_rr, exp_wr;
  logic             exp_busy;
  logic [CH*DB-1:0] exp_rdata;

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_infl[c] = 0; m_rel[c] = 0; m_wr[c] = 0; m_rdata[c] = '0;
    end
    m_ptr = 0; m_sr = 0; m_sw = 0;
  endtask

  task automatic clear_inputs();
    bus.read_valid = '0; bus.read_address = '0; bus.write_valid = '0;
    bus.write_address = '0; bus.write_data = '0;
    bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0;
  endtask

  // Mid-cycle: compute what the outputs must be during the current cycle.
  task automatic sample();
    @(negedge clk);
    if (!reset_n) model_reset();
    exp_busy = 1'b0;
    for (int c = 0; c < CH; c++) begin
      exp_rr[c] = m_infl[c] && (m_done[c] == cyc) && !m_wr[c];
      exp_wr[c] = m_infl[c] && (m_done[c] == cyc) &&  m_wr[c];
      exp_rdata[c*DB +: DB] = m_rdata[c];
      if (m_infl[c] || m_rel[c]) exp_busy = 1'b1;
    end
  endtask

  // Apply this cycle's inputs to the model, then move to just after the edge.
  task automatic advance();
    bit free [CH];
    bit found;
    int c;
    if (reset_n) begin
      for (int i = 0; i < CH; i++) free[i] = !m_infl[i] && !m_rel[i];
      for (int i = 0; i < CH; i++) begin
        if (m_rel[i] && !bus.read_valid[i] && !bus.write_valid[i]) m_rel[i] = 0;
        else if (m_infl[i] && m_done[i] == cyc) begin m_infl[i] = 0; m_rel[i] = 1; end
      end
      found = 0;
      if (!bus.load_en) begin
        for (int i = 0; i < CH; i++) begin
          c = (m_ptr + i) % CH;
          if (!found && free[c] && (bus.read_valid[c] || bus.write_valid[c])) begin
            found = 1; m_infl[c] = 1; m_done[c] = cyc + LAT; m_wr[c] = bus.write_valid[c];
            if (bus.write_valid[c]) begin
              m_mem[bus.write_address[c*AB +: AB]] = bus.write_data[c*DB +: DB];
              m_sw++;
            end else begin
              m_rdata[c] = m_mem[bus.read_address[c*AB +: AB]];
              m_sr++;
            end
            m_ptr = (c + 1) % CH;
          end
        end
      end
    end
    if (bus.load_en) m_mem[bus.load_addr] = bus.load_data;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
  endtask

  // Issue one read on channel c and wait (bounded) for its ready pulse.
  task automatic do_read(input int c, input logic [AB-1:0] a,
                         output bit seen, output int lat, output logic [DB-1:0] d);
    bus.read_valid[c] = 1'b1;
    bus.read_address[c*AB +: AB] = a;
    seen = 0; lat = -1; d = '0;
    for (int k = 0; k < 20 && !seen; k++) begin
      sample();
      if (bus.read_ready[c]) begin seen = 1; lat = k; d = bus.read_data[c*DB +: DB]; end
      advance();
    end
    bus.read_valid[c] = 1'b0;
    cycle();
  endtask

  task automatic do_write(input int c, input logic [AB-1:0] a, input logic [DB-1:0] v,
                          output bit seen, output int lat);
    bus.write_valid[c] = 1'b1;
    bus.write_address[c*AB +: AB] = a;
    bus.write_data[c*DB +: DB] = v;
    seen = 0; lat = -1;
    for (int k = 0; k < 20 && !seen; k++) begin
      sample();
      if (bus.write_ready[c]) begin seen = 1; lat = k; end
      advance();
    end
    bus.write_valid[c] = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    repeat (3) cycle();
    sample();
    checks++; if (bus.read_ready !== 4'b0)  begin errors++; $display("FAIL reset_read_ready got=%b exp=0", bus.read_ready); end
    checks++; if (bus.write_ready !== 4'b0) begin errors++; $display("FAIL reset_write_ready got=%b exp=0", bus.write_ready); end
    checks++; if (bus.busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.read_data !== 32'h0)  begin errors++; $display("FAIL reset_read_data got=%h exp=0", bus.read_data); end
`ifdef MEM_RESPONDER_STATS_EN
    checks++; if (bus.stat_reads !== 16'h0 || bus.stat_writes !== 16'h0) begin
      errors++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", bus.stat_reads, bus.stat_writes); end
`endif
    advance();
    reset_n = 1'b1;
  endtask

  task automatic test_preload_read();
    for (int a = 0; a < 256; a++) begin
      bus.load_en = 1'b1;
      bus.load_addr = AB'(a);
      bus.load_data = (a < 16) ? DB'(a % 8) : DB'($urandom);
      cycle();
    end
    bus.load_en = 1'b0;
    bus.read_valid[0] = 1'b1;
    bus.read_address[0*AB +: AB] = 8'd5;
    for (int k = 0; k < 5; k++) begin
      sample();
      checks++;
      if (bus.read_ready !== ((k == 2) ? 4'b0001 : 4'b0000)) begin
        errors++; $display("FAIL preload_ready k=%0d got=%b exp=%b", k, bus.read_ready, (k == 2) ? 4'b0001 : 4'b0000); end
      if (k == 2) begin
        checks++; if (bus.read_data[7:0] !== 8'd5) begin errors++; $display("FAIL preload_data got=%0d exp=5", bus.read_data[7:0]); end
      end
      if (k == 3) begin
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL release_busy got=%b exp=1", bus.busy); end
      end
      if (k == 4) begin
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", bus.busy); end
      end
      advance();
      if (k == 2) bus.read_valid[0] = 1'b0;
    end
  endtask

  task automatic test_all_channels();
    logic [CH-1:0] want;
    pulse_reset();
    for (int c = 0; c < CH; c++) bus.read_address[c*AB +: AB] = AB'(8 + c);
    bus.read_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      sample();
      want = (k >= 2 && k <= 5) ? CH'(1 << (k - 2)) : '0;
      checks++;
      if (bus.read_ready !== want) begin errors++; $display("FAIL rr_order k=%0d got=%b exp=%b", k, bus.read_ready, want); end
      if (k >= 2 && k <= 5) begin
        checks++;
        if (bus.read_data[(k-2)*DB +: DB] !== DB'(k - 2)) begin
          errors++; $display("FAIL rr_data ch=%0d got=%0d exp=%0d", k - 2, bus.read_data[(k-2)*DB +: DB], k - 2); end
      end
      advance();
      if (k >= 2 && k <= 5) bus.read_valid[k-2] = 1'b0;
    end
  endtask

  task automatic test_write_then_read();
    bit seen; int lat; logic [DB-1:0] d;
    do_write(1, 8'd16, 8'h2A, seen, lat);
    checks++; if (!seen || lat != LAT) begin errors++; $display("FAIL write_ready_latency got=%0d exp=%0d", lat, LAT); end
    do_read(2, 8'd16, seen, lat, d);
    checks++; if (!seen || d !== 8'h2A) begin errors++; $display("FAIL write_read_data got=%h exp=2a seen=%0d", d, seen); end
  endtask

  task automatic test_hold_valid();
    int cnt;
    bus.read_valid[0] = 1'b1;
    bus.read_address[0*AB +: AB] = 8'd3;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin sample(); if (bus.read_ready[0]) cnt++; advance(); end
    checks++; if (cnt != 1) begin errors++; $display("FAIL hold_pulses got=%0d exp=1", cnt); end
    bus.read_valid[0] = 1'b0;
    cycle();
    bus.read_valid[0] = 1'b1;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      sample();
      if (bus.read_ready[0]) begin
        cnt++;
        checks++; if (bus.read_data[7:0] !== 8'd3) begin errors++; $display("FAIL rearm_data got=%0d exp=3", bus.read_data[7:0]); end
      end
      advance();
    end
    checks++; if (cnt != 1) begin errors++; $display("FAIL rearm_pulses got=%0d exp=1", cnt); end
    bus.read_valid[0] = 1'b0;
    repeat (2) cycle();
  endtask

  task automatic test_reset_mid();
    bit seen; int lat; logic [DB-1:0] d;
    bus.read_valid[3] = 1'b1;
    bus.read_address[3*AB +: AB] = 8'd5;
    cycle();
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample();
      checks++; if (bus.read_ready !== 4'b0 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL midreset k=%0d ready=%b busy=%b exp=0/0", k, bus.read_ready, bus.busy); end
      advance();
    end
    bus.read_valid[3] = 1'b0;
    reset_n = 1'b1;
    cycle();
    do_read(3, 8'd5, seen, lat, d);
    checks++; if (!seen || lat != LAT || d !== 8'd5) begin
      errors++; $display("FAIL after_reset_read got=%0d lat=%0d exp=5 lat=%0d", d, lat, LAT); end
    bus.write_valid[3] = 1'b1;
    bus.write_address[3*AB +: AB] = 8'd20;
    bus.write_data[3*DB +: DB] = 8'h77;
    cycle();
    reset_n = 1'b0;
    cycle();
    bus.write_valid[3] = 1'b0;
    reset_n = 1'b1;
    cycle();
    do_read(3, 8'd20, seen, lat, d);
    checks++; if (!seen || d !== 8'h77) begin errors++; $display("FAIL committed_write got=%h exp=77", d); end
  endtask

  task automatic test_load_contention();
    logic [CH-1:0] want;
    bit seen; int lat; logic [DB-1:0] d;
    pulse_reset();
    bus.read_valid[0] = 1'b1; bus.read_address[0*AB +: AB] = 8'd2;
    bus.read_valid[1] = 1'b1; bus.read_address[1*AB +: AB] = 8'd4;
    bus.load_en = 1'b1; bus.load_addr = 8'd200; bus.load_data = 8'h55;
    for (int k = 0; k < 7; k++) begin
      sample();
      want = (k == 3) ? 4'b0001 : (k == 4) ? 4'b0010 : 4'b0000;
      checks++; if (bus.read_ready !== want) begin
        errors++; $display("FAIL load_stall k=%0d got=%b exp=%b", k, bus.read_ready, want); end
      advance();
      if (k == 0) bus.load_en = 1'b0;
      if (k == 3) bus.read_valid[0] = 1'b0;
      if (k == 4) bus.read_valid[1] = 1'b0;
    end
    do_read(2, 8'd200, seen, lat, d);
    checks++; if (!seen || d !== 8'h55) begin errors++; $display("FAIL load_data got=%h exp=55", d); end
  endtask

`ifdef MEM_RESPONDER_STATS_EN
  task automatic test_stats();
    bit seen; int lat; logic [DB-1:0] d;
    pulse_reset();
    do_read(0, 8'd1, seen, lat, d);
    do_read(1, 8'd2, seen, lat, d);
    do_write(2, 8'd30, 8'h11, seen, lat);
    do_read(3, 8'd30, seen, lat, d);
    do_write(0, 8'd31, 8'h22, seen, lat);
    checks++; if (bus.stat_reads !== 16'd3)  begin errors++; $display("FAIL stat_reads got=%0d exp=3", bus.stat_reads); end
    checks++; if (bus.stat_writes !== 16'd2) begin errors++; $display("FAIL stat_writes got=%0d exp=2", bus.stat_writes); end
  endtask
`endif

  task automatic test_random();
    int st [CH];
    int kind;
    for (int c = 0; c < CH; c++) st[c] = 0;
    clear_inputs();
    for (int k = 0; k < 500; k++) begin
      sample();
      checks++; if (bus.read_ready !== exp_rr)  begin errors++; $display("FAIL rnd_read_ready cyc=%0d got=%b exp=%b", cyc, bus.read_ready, exp_rr); end
      checks++; if (bus.write_ready !== exp_wr) begin errors++; $display("FAIL rnd_write_ready cyc=%0d got=%b exp=%b", cyc, bus.write_ready, exp_wr); end
      checks++; if (bus.busy !== exp_busy)      begin errors++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, bus.busy, exp_busy); end
      checks++; if (bus.read_data !== exp_rdata) begin errors++; $display("FAIL rnd_read_data cyc=%0d got=%h exp=%h", cyc, bus.read_data, exp_rdata); end
`ifdef MEM_RESPONDER_STATS_EN
      checks++; if (bus.stat_reads !== 16'(m_sr) || bus.stat_writes !== 16'(m_sw)) begin
        errors++; $display("FAIL rnd_stats cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, bus.stat_reads, bus.stat_writes, m_sr, m_sw); end
`endif
      for (int c = 0; c < CH; c++) if (exp_rr[c] || exp_wr[c]) st[c] = 2;
      advance();
      bus.load_en   = ($urandom_range(0, 9) == 0);
      bus.load_addr = AB'($urandom_range(0, 31));
      bus.load_data = DB'($urandom);
      for (int c = 0; c < CH; c++) begin
        if (st[c] == 0 && $urandom_range(0, 3) == 0) begin
          kind = $urandom_range(0, 2);
          bus.read_valid[c]  = (kind != 1);
          bus.write_valid[c] = (kind != 0);
          bus.read_address[c*AB +: AB]  = AB'($urandom_range(0, 31));
          bus.write_address[c*AB +: AB] = AB'($urandom_range(0, 31));
          bus.write_data[c*DB +: DB]    = DB'($urandom);
          st[c] = 1;
        end else if (st[c] == 2 && $urandom_range(0, 2) == 0) begin
          bus.read_valid[c]  = 1'b0;
          bus.write_valid[c] = 1'b0;
          st[c] = 0;
        end
      end
    end
    clear_inputs();
    repeat (8) cycle();
  endtask

  initial begin
    test_reset();
    test_preload_read();
    test_all_channels();
    test_write_then_read();
    test_hold_valid();
    test_reset_mid();
    test_load_contention();
`ifdef MEM_RESPONDER_STATS_EN
    test_stats();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time=%0t limit=100000", $time);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Synthesizable responder for the GPU's multi-channel memory request interface; the device-side end of the protocol that the core memory controllers initiate.
- Each channel issues read/write requests held until ready; the block arbitrates channels round-robin onto one single-port storage array and returns a one-cycle ready pulse after a fixed latency.
- Used as the data/program memory in system benches and FPGA builds.
- Includes a backdoor load port for preloading kernels and matrices.

Parameters:
- ADDR_BITS, 8, address width; the array holds 2**ADDR_BITS words.
- DATA_BITS, 8, word width (16 for program memory).
- CHANNELS, 4, number of independent request channels.
- LATENCY, 2, cycles from grant to ready pulse; legal range 1..15.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- read_valid  in  CHANNELS  per-channel read request, held until ready
- read_address  in  CHANNELS*ADDR_BITS  per-channel read address
- read_ready  out  CHANNELS  one-cycle read completion pulse
- read_data  out  CHANNELS*DATA_BITS  read data, valid with read_ready
- write_valid  in  CHANNELS  per-channel write request, held until ready
- write_address  in  CHANNELS*ADDR_BITS  per-channel write address
- write_data  in  CHANNELS*DATA_BITS  per-channel write data
- write_ready  out  CHANNELS  one-cycle write completion pulse
- load_en  in  1  backdoor write strobe
- load_addr  in  ADDR_BITS  backdoor address
- load_data  in  DATA_BITS  backdoor data
- busy  out  1  high when any channel is outside IDLE

Behaviour:
- Reset (async, reset_n=0): all outputs 0, every channel FSM in IDLE, arbiter pointer 0, latency counters 0. Array contents are not reset and are preserved across reset.
- Per-channel FSM:
  - IDLE: a request is pending when read_valid or write_valid is high. Granted -> WAIT.
  - WAIT: counts LATENCY-1 cycles, then -> RESPOND. With LATENCY=1, WAIT is skipped.
  - RESPOND: the corresponding ready is high for exactly one cycle -> RELEASE.
  - RELEASE: waits for both valids low -> IDLE. A valid held high never re-triggers an access.
- Arbitration:
  - One array access per cycle. Grant goes to the first pending IDLE channel at or after the pointer; the pointer moves to the granted channel+1 (mod CHANNELS).
  - The grant is combinational on registered state. Uncontended request seen at cycle t: granted at t, ready at t+LATENCY.
- Access occurs in the grant cycle:
  - Write: stores write_data[c] into the array.
  - Read: registers the array word into the channel's data holding register. read_data[c] holds that value from RESPOND until the next grant on that channel.
- Same-cycle read_valid and write_valid on one channel: write is performed, read is ignored, and write_ready pulses.
- Write granted at cycle t followed by a read of the same address granted at t+1 or later returns the new data.
- load_en: writes load_data into the array and suppresses all grants that cycle. Pending requests wait; the pointer is unchanged.
- Addresses wrap naturally within ADDR_BITS. No out-of-range case exists.
- Reset mid-operation: in-flight accesses are abandoned with no ready pulse. A write already granted remains committed.
- busy = OR over channels of (state != IDLE).

Optional Feature:
- Macro: MEM_RESPONDER_STATS_EN.
- Defined: adds outputs stat_reads and stat_writes, 16 bits each. They count granted reads and writes, saturate at 16'hFFFF, and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mem_responder_pkg holds:
  - the channel state enum (IDLE, WAIT, RESPOND, RELEASE);
  - the LATENCY counter width constant (4 bits);
  - the stats counter width constant (16).
- One sub-module: rr_arbiter, parameterized on CHANNELS. Inputs: request vector, enable. Outputs: one-hot grant and the registered pointer.

Test Plan:
- Preload addr 0..15 with 0..7,0..7 via load_en. Channel 0 read addr 5, LATENCY=2 -> read_ready[0] pulses exactly at t+2 with read_data[0]=5, one cycle wide.
- All 4 channels request reads at cycle t (pointer 0) -> grants at t, t+1, t+2, t+3 in order 0,1,2,3; ready pulses at t+2..t+5.
- Channel 1 writes 0x2A to addr 16, then channel 2 reads addr 16 after write_ready -> read_data[2]=0x2A.
- Channel 0 holds read_valid high for 10 cycles after ready -> exactly one read_ready pulse. Dropping valid and re-asserting it yields a second pulse.
- Assert reset_n=0 while channel 3 is in WAIT -> read_ready stays 0, busy=0, array contents unchanged. After release, a new request completes normally.
- MEM_RESPONDER_STATS_EN defined, 3 reads and 2 writes -> stat_reads=3, stat_writes=2. A load_en cycle during contention delays all grants by one cycle.
